// File: rtl/kyber_pkg.sv
// kyber_pkg: constants and types shared by the coefficient read-out path.
//   N      - polynomial length (coefficients per sweep)
//   Q      - coefficient modulus
//   DATA_W - coefficient width
//   ADDR_W - coefficient BRAM address width
//   state_e - read-out FSM state encoding
package kyber_pkg;

    localparam int unsigned N      = 256;
    localparam int unsigned Q      = 3329;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/coef_fifo2.sv
// coef_fifo2: two-entry FIFO that absorbs the BRAM read latency.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (flushes the FIFO)
//   push_i, din_i - write din_i at the tail
//   pop_i         - drop the head entry
//   head_o        - current head entry (valid while occ_o != 0)
//   occ_o         - number of stored entries, 0..2
// The caller must never push when full or pop when empty.
module coef_fifo2
    import kyber_pkg::*;
#(
    parameter int unsigned DW = kyber_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    occ_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    occ_q;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign head_o = mem_q[rd_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sweeps the coefficient BRAM once per start and
// presents the coefficients as a valid/ready stream with a last flag.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - begin a sweep (sampled only while idle)
//   busy, done      - sweep in progress / one-cycle end-of-sweep pulse
//   raddr, rdata    - BRAM read port (rdata valid one cycle after raddr)
//   m_valid, m_data, m_last, m_ready - output stream
// Build option: define BRAM_READER_BITREV_EN to emit coefficients in
// bit-reversed address order; otherwise addresses run 0..2^ADDR_W-1.
module bram_stream_reader
    import kyber_pkg::*;
#(
    parameter int unsigned ADDR_W = kyber_pkg::ADDR_W,
    parameter int unsigned DATA_W = kyber_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << ADDR_W) - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               inflight_q, inflight_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         occ;
    logic [DATA_W-1:0]  head;
    logic               pop;
    logic               issue;
    logic               final_issue;
    logic               last_pop;

    // Counter-to-address mapping
    function automatic logic [ADDR_W-1:0] addr_map(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
`ifdef BRAM_READER_BITREV_EN
        for (int i = 0; i < int'(ADDR_W); i++) begin
            r[i] = a[int'(ADDR_W) - 1 - i];
        end
`else
        r = a;
`endif
        return r;
    endfunction

    assign pop         = (occ != 2'd0) && m_ready;
    // Credit check: entries held plus the read in flight, minus the one leaving
    assign issue       = (state_q == ST_RUN) &&
                         (({1'b0, occ} + 3'(inflight_q) - 3'(pop)) < 3'd2);
    assign final_issue = issue && (cnt_q == LAST_IDX);
    assign last_pop    = pop && (beat_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)       state_d = ST_RUN;
            ST_RUN:   if (final_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop)    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values
    always_comb begin
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        raddr_d    = raddr_q;
        inflight_d = issue;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if ((state_q == ST_IDLE) && start) begin
            cnt_d   = '0;
            beat_d  = '0;
            raddr_d = addr_map('0);
            busy_d  = 1'b1;
        end
        // raddr already holds the address being read, so advance it to the next one
        if (issue) begin
            cnt_d   = cnt_q + CNT_W'(1);
            raddr_d = addr_map(cnt_q[ADDR_W-1:0] + ADDR_W'(1));
        end
        if (pop) begin
            beat_d = beat_q + CNT_W'(1);
        end
        if ((state_q == ST_DRAIN) && last_pop) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    // Registered outputs and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            beat_q     <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            raddr_q    <= raddr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    coef_fifo2 #(
        .DW(DATA_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .pop_i  (pop),
        .din_i  (rdata),
        .head_o (head),
        .occ_o  (occ)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign raddr   = raddr_q;
    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign m_last  = m_valid && (beat_q == LAST_IDX);

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Downstream read-out stage for the 256 × 12-bit coefficient BRAM (1-cycle read latency). On `start` it sweeps all 256 addresses, absorbs the read latency in a 2-entry buffer and presents the coefficients as a valid/ready stream with a last flag. It sits between the polynomial-multiplier result memory and the output/serialisation logic, and sustains one coefficient per cycle under full backpressure without dropping or duplicating data.

## Interface
- `ADDR_W`, 8, BRAM address width; sweep length = 2^ADDR_W
- `DATA_W`, 12, coefficient width
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `busy`  out  1  high from the edge that accepts `start` until `done`
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `raddr`  out  ADDR_W  BRAM read address, registered
- `rdata`  in  DATA_W  BRAM `dout`, valid one cycle after `raddr`
- `m_valid`  out  1  output coefficient valid
- `m_data`  out  DATA_W  output coefficient
- `m_last`  out  1  high with the 256th beat
- `m_ready`  in  1  sink accepts beat when `m_valid && m_ready`

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`. Address counter cleared, buffer empty.
  - RUN → DRAIN once the final read (address 255) is issued.
  - DRAIN → IDLE when the last beat is handshaked. `done` pulses.
- Issue rule for cycle t: `issue = (state==RUN) && (occ + inflight − pop < 2)`.
  - `occ`: buffer entries (0..2). `inflight`: read issued last cycle (0/1). `pop = m_valid && m_ready`.
  - On issue, the counter increments and `inflight` is set for the next cycle.
- Data path: when `inflight` is set, `rdata` is written into the buffer at the next edge. Buffer is a FIFO: head drives `m_data`; `m_valid = (occ != 0)`.
- Beat count: 9-bit, increments on `pop`. `m_last = m_valid && (beat_cnt == 255)`.
- The buffer never overflows. The credit rule guarantees `occ + inflight ≤ 2` at every edge.
- `start` while not IDLE is ignored. `start` held high re-triggers immediately after `done`.
- Reset asserted mid-sweep:
  - State returns to IDLE and the buffer is flushed.
  - No further beats are presented; no `done` is generated.
- Reset values: `busy=0`, `done=0`, `raddr=0`, `m_valid=0`, `m_data=0`, `m_last=0`.

## Timing
- Let E0 be the edge sampling `start`=1 in IDLE.
  - `busy=1` and `raddr=0` after E0.
  - `rdata` for address 0 is valid after E1 and captured at E2.
  - `m_valid=1` after E2 (latency 2 cycles from the sweep start).
- With `m_ready` held 1: one beat per cycle, 256 consecutive beats, last beat in cycle E2+255.
  - `done=1` and `busy=0` in the following cycle. Total 259 cycles from E0 to `done`.
- `m_ready` low: `m_data`/`m_valid`/`m_last` stay stable. At most 2 reads are outstanding.
- `m_ready` returning to 1: the next beat goes out in the same cycle (head already valid), with no bubble.

## Configuration
- `BRAM_READER_BITREV_EN`
  - Defined: `raddr` = bit-reverse of the sweep counter over ADDR_W bits, so coefficients are emitted in bit-reversed order (NTT-domain output). Beat count, `m_last` and `done` are unchanged.
  - Undefined: `raddr` = counter, natural order 0..255.

## Structure
- Shared package `kyber_pkg`: `N=256`, `Q=3329`, `DATA_W=12`, `ADDR_W=8`, FSM state enum.
- One sub-module `coef_fifo2`: 2-entry FIFO with push, pop, `occ`, head output and async reset.
- Top level holds the FSM, address/beat counters, credit logic and optional bit-reversal.

## Test plan
- BRAM model preloaded with `mem[i]=i`; `start` pulse with `m_ready=1`.
  - Required: 256 beats with `m_data`=0..255 in consecutive cycles, first beat 2 cycles after E0.
  - Required: `m_last` only on value 255; `done` one cycle later; 259 cycles total.
- Random `m_ready` (50%), `mem[i]=(i*17)%3329`.
  - Required: exact in-order sequence with no loss or duplication.
  - Required: outputs stable while stalled; `occ+inflight ≤ 2` asserted every cycle.
- `m_ready=0` for 10 cycles after the first `m_valid`, then 1.
  - Required: value 0 held for 10 cycles, then 0..255 without a bubble.
- `rst` pulsed at beat 100, then new `start`.
  - Required: outputs at reset values immediately (async), no `done`; new sweep restarts from 0.
- `start` re-pulsed during RUN; `start` held high continuously.
  - Required: the re-pulse is ignored; held `start` gives back-to-back sweeps, each with its own `done`.
- `BRAM_READER_BITREV_EN` defined, `mem[i]=i`.
  - Required: beats 0,128,64,192,…,255.
  - Required: `m_last` on beat 256 (value 255).
